fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//  Shares the write side of one byte FIFO between two packet producers, A and B (e.g. SPI host path, Maple RX path).
//  Grants are packet-atomic. A producer is granted only when the FIFO has free space for its whole declared packet,
//  so producers never overrun. Sits directly in front of the FIFO's indata/instrobe/inavail/inavail_cnt inputs.
// PARAMETERS
//  DEPTH    16    capacity of the downstream FIFO in bytes; largest legal packet length
//  TIMEOUT  1024  idle cycles allowed inside a grant before abort (used only with FIFO_ARB_TIMEOUT_EN)
// PORTS
//  clk               in   1  single clock; all logic on posedge
//  rst_n             in   1  asynchronous, active-low reset
//  a_req / b_req     in   1  producer requests a grant; must be held until gnt or rej
//  a_len / b_len     in   8  packet length in bytes; sampled in the grant cycle
//  a_data / b_data   in   8  packet byte
//  a_strobe/b_strobe in   1  byte valid; counted only while that producer holds the grant
//  a_gnt / b_gnt     out  1  grant held; at most one high
//  a_done / b_done   out  1  1-cycle pulse: packet completed
//  a_rej / b_rej     out  1  1-cycle pulse: request rejected (illegal length)
//  err               out  1  1-cycle pulse: grant aborted by timeout
//  fifo_indata       out  8  muxed byte to the FIFO
//  fifo_instrobe     out  1  write strobe to the FIFO
//  fifo_inavail      in   1  FIFO not full
//  fifo_inavail_cnt  in   8  free FIFO slots
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE; gnt, done, rej, err all 0; priority = A; remaining = 0; idle timer = 0.
//  - States: IDLE, GNT_A, GNT_B. Only IDLE evaluates requests.
//  - Legal length: 1 <= len <= DEPTH. An illegal length gives rej for that producer in the next cycle and no grant.
//  - Eligible: req, legal len, and len <= fifo_inavail_cnt. If both are eligible, the priority holder wins.
//    An ineligible request waits without starvation; priority is unchanged.
//  - Grant is registered: a request seen in IDLE at cycle n gives gnt=1 and state GNT_x at n+1.
//    len is latched into an 8-bit remaining counter at grant.
//  - While GNT_x:
//    - fifo_indata = x_data and fifo_instrobe = x_strobe & fifo_inavail (combinational; zero added latency).
//    - The other producer's strobes are dropped and not counted.
//  - Each accepted byte decrements remaining. An accepted byte with remaining==1 at cycle m gives, at m+1:
//    gnt=0, done=1, state IDLE, priority passes to the other producer.
//    Earliest next grant is m+2 (one IDLE cycle minimum).
//  - Deasserting req mid-grant has no effect; the grant lasts until len bytes are accepted (or timeout).
//  - In IDLE: fifo_instrobe=0, fifo_indata=0.
//  - Reset mid-packet: grant dropped immediately; partial bytes already in the FIFO are not retracted.
// CONFIGURATION
//  FIFO_ARB_TIMEOUT_EN defined:
//    - Idle timer clears on grant and on each accepted byte, and increments on other GNT cycles.
//    - At TIMEOUT-1: state IDLE, gnt=0, err=1, no done, priority passes to the other producer.
//    - Bytes already written stay in the FIFO.
//  FIFO_ARB_TIMEOUT_EN undefined: no timer; err tied 0; a grant may last indefinitely.
// STRUCTURE
//  - Shared package fifo_arb_pkg: state encoding (IDLE/GNT_A/GNT_B), requester IDs (REQ_A=0, REQ_B=1),
//    length width constant (8).
//  - One sub-module, fifo_arb_watchdog: the TIMEOUT counter with clear/enable/expire.
//    Instantiated only under FIFO_ARB_TIMEOUT_EN.
// TESTING (bench pairs with fifo, DEPTH=16)
//  - Single A packet: a_req, a_len=4, 4 strobes after gnt, bytes 11,22,33,44
//    -> FIFO holds 11,22,33,44; a_done 1 cycle after 4th byte; a_gnt low.
//  - Both request, len=2 each, from reset
//    -> A granted first; B granted 2 cycles after A's last byte; next contested round goes to B.
//  - Space check: FIFO holds 14 bytes, a_len=3
//    -> no grant; after 1 FIFO read (inavail_cnt=3) -> a_gnt next cycle.
//  - Illegal lengths: a_len=0, then b_len=17 -> a_rej then b_rej pulses; no gnt; FIFO unchanged.
//  - Cross-traffic: during A grant, b_strobe with data 0xFF
//    -> 0xFF never in FIFO; A's remaining count unaffected.
//  - With FIFO_ARB_TIMEOUT_EN, TIMEOUT=8: grant A with len=5, send 2 bytes, stop
//    -> err pulse, a_gnt low, no a_done, 2 bytes in FIFO; rst_n low mid-packet -> all outputs 0 at once.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the two-producer FIFO write arbiter.
package fifo_arb_pkg;

  localparam int unsigned LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // A packet length is legal when it is non-zero and fits in an empty FIFO.
  function automatic logic len_legal(input logic [LEN_W-1:0] len, input int unsigned depth);
    return (len != '0) && (32'(len) <= depth);
  endfunction

endpackage

// File: rtl/fifo_arb_watchdog.sv
// Idle-cycle watchdog for an active grant: clears on clr, counts while en,
// and flags expire in the cycle the count sits at TIMEOUT-1.
module fifo_arb_watchdog
  import fifo_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Idle counter; saturates at the terminal value so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != TERM)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = en & ~clr & (count == TERM);

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-atomic arbiter sharing one byte FIFO write port between producers A and B.
// A producer is granted only when the FIFO has room for its whole packet.
// Optional grant timeout is enabled by defining FIFO_ARB_TIMEOUT_EN.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_req,
  input  logic [LEN_W-1:0] a_len,
  input  logic [7:0]       a_data,
  input  logic             a_strobe,
  input  logic             b_req,
  input  logic [LEN_W-1:0] b_len,
  input  logic [7:0]       b_data,
  input  logic             b_strobe,
  output logic             a_gnt,
  output logic             b_gnt,
  output logic             a_done,
  output logic             b_done,
  output logic             a_rej,
  output logic             b_rej,
  output logic             err,
  output logic [7:0]       fifo_indata,
  output logic             fifo_instrobe,
  input  logic             fifo_inavail,
  input  logic [7:0]       fifo_inavail_cnt
);

  arb_state_t       state, state_n;
  req_id_t          prio, prio_n;
  logic [LEN_W-1:0] remaining, remaining_n;

  logic a_legal, b_legal;
  logic a_elig, b_elig;
  logic accepted;
  logic last_byte;
  logic expire;
  logic a_done_n, b_done_n, a_rej_n, b_rej_n, err_n;

  // Request qualification: legal length and enough free FIFO space.
  assign a_legal = len_legal(a_len, DEPTH);
  assign b_legal = len_legal(b_len, DEPTH);
  assign a_elig  = a_req & a_legal & (a_len <= fifo_inavail_cnt);
  assign b_elig  = b_req & b_legal & (b_len <= fifo_inavail_cnt);

  // A byte is accepted only from the grant holder while the FIFO is not full.
  assign accepted  = (((state == GNT_A) & a_strobe) | ((state == GNT_B) & b_strobe)) & fifo_inavail;
  assign last_byte = accepted & (remaining == LEN_W'(1));

`ifdef FIFO_ARB_TIMEOUT_EN
  logic wd_clr;
  logic wd_en;

  assign wd_clr = (state == IDLE) | accepted;
  assign wd_en  = (state != IDLE);

  fifo_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wd_clr),
    .en    (wd_en),
    .expire(expire)
  );
`else
  logic unused_timeout;

  assign expire         = 1'b0;
  assign unused_timeout = |32'(TIMEOUT);
`endif

  // State, priority, length counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= REQ_A;
      remaining <= '0;
      a_gnt     <= 1'b0;
      b_gnt     <= 1'b0;
      a_done    <= 1'b0;
      b_done    <= 1'b0;
      a_rej     <= 1'b0;
      b_rej     <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      prio      <= prio_n;
      remaining <= remaining_n;
      a_gnt     <= (state_n == GNT_A);
      b_gnt     <= (state_n == GNT_B);
      a_done    <= a_done_n;
      b_done    <= b_done_n;
      a_rej     <= a_rej_n;
      b_rej     <= b_rej_n;
      err       <= err_n;
    end
  end

  // Next-state: arbitration in IDLE, byte counting and abort while granted.
  always_comb begin
    state_n     = state;
    prio_n      = prio;
    remaining_n = remaining;
    case (state)
      IDLE: begin
        if (a_elig && (!b_elig || (prio == REQ_A))) begin
          state_n     = GNT_A;
          remaining_n = a_len;
        end else if (b_elig) begin
          state_n     = GNT_B;
          remaining_n = b_len;
        end
      end
      GNT_A, GNT_B: begin
        if (accepted) begin
          remaining_n = remaining - LEN_W'(1);
          if (last_byte) begin
            state_n = IDLE;
            prio_n  = (state == GNT_A) ? REQ_B : REQ_A;
          end
        end else if (expire) begin
          state_n = IDLE;
          prio_n  = (state == GNT_A) ? REQ_B : REQ_A;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs: FIFO write mux (combinational) and next values of the status pulses.
  always_comb begin
    fifo_indata   = '0;
    fifo_instrobe = 1'b0;
    a_done_n      = 1'b0;
    b_done_n      = 1'b0;
    a_rej_n       = 1'b0;
    b_rej_n       = 1'b0;
    err_n         = 1'b0;
    case (state)
      IDLE: begin
        a_rej_n = a_req & ~a_legal;
        b_rej_n = b_req & ~b_legal;
      end
      GNT_A: begin
        fifo_indata   = a_data;
        fifo_instrobe = accepted;
        a_done_n      = last_byte;
        err_n         = expire;
      end
      GNT_B: begin
        fifo_indata   = b_data;
        fifo_instrobe = accepted;
        b_done_n      = last_byte;
        err_n         = expire;
      end
      default: begin
        fifo_indata   = '0;
        fifo_instrobe = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a behavioural 16-byte FIFO.
// Timeout checks are included when FIFO_ARB_TIMEOUT_EN is defined.
module tb_fifo_write_arbiter;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       a_req = 1'b0, b_req = 1'b0;
  logic [7:0] a_len = 8'd0, b_len = 8'd0;
  logic [7:0] a_data = 8'd0, b_data = 8'd0;
  logic       a_strobe = 1'b0, b_strobe = 1'b0;
  logic       a_gnt, b_gnt, a_done, b_done, a_rej, b_rej, err;
  logic [7:0] fifo_indata;
  logic       fifo_instrobe;
  logic       fifo_inavail;
  logic [7:0] fifo_inavail_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fq[$];
  int         fill = 0;
  bit         tb_clr = 1'b0, tb_pop = 1'b0, tb_load = 1'b0;

  fifo_write_arbiter #(
    .DEPTH  (16),
    .TIMEOUT(8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .a_req           (a_req),
    .a_len           (a_len),
    .a_data          (a_data),
    .a_strobe        (a_strobe),
    .b_req           (b_req),
    .b_len           (b_len),
    .b_data          (b_data),
    .b_strobe        (b_strobe),
    .a_gnt           (a_gnt),
    .b_gnt           (b_gnt),
    .a_done          (a_done),
    .b_done          (b_done),
    .a_rej           (a_rej),
    .b_rej           (b_rej),
    .err             (err),
    .fifo_indata     (fifo_indata),
    .fifo_instrobe   (fifo_instrobe),
    .fifo_inavail    (fifo_inavail),
    .fifo_inavail_cnt(fifo_inavail_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural downstream FIFO; bench controls for clear, one read, and a 14-byte preload.
  always @(posedge clk) begin
    if (tb_clr) begin
      fq.delete();
    end else begin
      if (fifo_instrobe && fq.size() < 16) fq.push_back(fifo_indata);
      if (tb_pop && fq.size() > 0) void'(fq.pop_front());
      if (tb_load) for (int i = 0; i < 14; i++) fq.push_back(8'hEE);
    end
    fill <= fq.size();
  end

  assign fifo_inavail     = (fill < 16);
  assign fifo_inavail_cnt = 8'(16 - fill);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    a_req    = 1'b0;
    b_req    = 1'b0;
    a_len    = 8'd0;
    b_len    = 8'd0;
    a_data   = 8'd0;
    b_data   = 8'd0;
    a_strobe = 1'b0;
    b_strobe = 1'b0;
    tb_clr   = 1'b1;
    tick();
    tb_clr   = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic a_byte(input logic [7:0] v);
    a_strobe = 1'b1;
    a_data   = v;
    #1;
    chk("a_instrobe", fifo_instrobe, 1);
    chk("a_indata", fifo_indata, v);
    tick();
    a_strobe = 1'b0;
  endtask

  task automatic b_byte(input logic [7:0] v);
    b_strobe = 1'b1;
    b_data   = v;
    #1;
    chk("b_instrobe", fifo_instrobe, 1);
    chk("b_indata", fifo_indata, v);
    tick();
    b_strobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    // Asynchronous reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_done", {a_done, b_done}, 0);
    chk("rst_rej", {a_rej, b_rej}, 0);
    chk("rst_err", err, 0);
    chk("rst_instrobe", fifo_instrobe, 0);
    chk("rst_indata", fifo_indata, 0);
    do_reset();

    // Single A packet of 4 bytes
    a_req = 1'b1;
    a_len = 8'd4;
    tick();
    chk("t1_a_gnt", a_gnt, 1);
    chk("t1_b_gnt", b_gnt, 0);
    a_req = 1'b0;
    a_byte(8'h11);
    a_byte(8'h22);
    a_byte(8'h33);
    chk("t1_done_early", a_done, 0);
    chk("t1_gnt_mid", a_gnt, 1);
    a_byte(8'h44);
    chk("t1_a_done", a_done, 1);
    chk("t1_gnt_drop", a_gnt, 0);
    a_strobe = 1'b1;
    a_data   = 8'h99;
    #1;
    chk("t1_idle_instrobe", fifo_instrobe, 0);
    chk("t1_idle_indata", fifo_indata, 0);
    tick();
    a_strobe = 1'b0;
    chk("t1_done_pulse", a_done, 0);
    chk("t1_fill", fill, 4);
    chk("t1_q0", fq[0], 8'h11);
    chk("t1_q1", fq[1], 8'h22);
    chk("t1_q2", fq[2], 8'h33);
    chk("t1_q3", fq[3], 8'h44);

    // Both request from reset: A first, then B, then A again
    do_reset();
    a_req = 1'b1;
    b_req = 1'b1;
    a_len = 8'd2;
    b_len = 8'd2;
    tick();
    chk("t2_a_first", a_gnt, 1);
    chk("t2_b_wait", b_gnt, 0);
    a_byte(8'h01);
    a_byte(8'h02);
    chk("t2_a_done", a_done, 1);
    chk("t2_idle_a", a_gnt, 0);
    chk("t2_idle_b", b_gnt, 0);
    tick();
    chk("t2_b_gnt", b_gnt, 1);
    chk("t2_a_lose", a_gnt, 0);
    b_byte(8'h03);
    b_byte(8'h04);
    chk("t2_b_done", b_done, 1);
    tick();
    chk("t2_a_again", a_gnt, 1);
    chk("t2_fill", fill, 4);
    chk("t2_q2", fq[2], 8'h03);

    // Reset mid-packet drops everything without a clock edge
    a_strobe = 1'b1;
    a_data   = 8'h05;
    #1;
    chk("t2_pre_rst_strobe", fifo_instrobe, 1);
    rst_n = 1'b0;
    #1;
    chk("t2_rst_a_gnt", a_gnt, 0);
    chk("t2_rst_b_gnt", b_gnt, 0);
    chk("t2_rst_strobe", fifo_instrobe, 0);
    chk("t2_rst_indata", fifo_indata, 0);
    do_reset();

    // Space check: 14 bytes held, a_len=3 waits until one read
    tb_load = 1'b1;
    tick();
    tb_load = 1'b0;
    a_req = 1'b1;
    a_len = 8'd3;
    tick();
    chk("t3_no_gnt1", a_gnt, 0);
    tick();
    chk("t3_no_gnt2", a_gnt, 0);
    tb_pop = 1'b1;
    tick();
    tb_pop = 1'b0;
    chk("t3_no_gnt3", a_gnt, 0);
    tick();
    chk("t3_gnt", a_gnt, 1);
    a_req = 1'b0;
    a_byte(8'hA0);
    a_byte(8'hA1);
    a_byte(8'hA2);
    chk("t3_done", a_done, 1);
    chk("t3_fill", fill, 16);

    // Illegal lengths, then DEPTH as largest legal length
    do_reset();
    a_req = 1'b1;
    a_len = 8'd0;
    tick();
    chk("t4_a_rej", a_rej, 1);
    chk("t4_a_nogrant", a_gnt, 0);
    chk("t4_b_rej_quiet", b_rej, 0);
    a_req = 1'b0;
    tick();
    chk("t4_a_rej_pulse", a_rej, 0);
    b_req = 1'b1;
    b_len = 8'd17;
    tick();
    chk("t4_b_rej", b_rej, 1);
    chk("t4_b_nogrant", b_gnt, 0);
    chk("t4_a_rej_quiet", a_rej, 0);
    b_req = 1'b0;
    tick();
    chk("t4_b_rej_pulse", b_rej, 0);
    chk("t4_fill", fill, 0);
    b_req = 1'b1;
    b_len = 8'd16;
    tick();
    chk("t4_len16_gnt", b_gnt, 1);
    chk("t4_len16_rej", b_rej, 0);

    // Cross-traffic: B strobes during A's grant are dropped
    do_reset();
    a_req = 1'b1;
    a_len = 8'd2;
    tick();
    chk("t5_a_gnt", a_gnt, 1);
    a_req    = 1'b0;
    b_strobe = 1'b1;
    b_data   = 8'hFF;
    #1;
    chk("t5_b_blocked", fifo_instrobe, 0);
    tick();
    tick();
    chk("t5_still_gnt", a_gnt, 1);
    chk("t5_no_done", a_done, 0);
    a_byte(8'h55);
    a_byte(8'h66);
    chk("t5_done", a_done, 1);
    b_strobe = 1'b0;
    chk("t5_fill", fill, 2);
    chk("t5_q0", fq[0], 8'h55);
    chk("t5_q1", fq[1], 8'h66);

`ifdef FIFO_ARB_TIMEOUT_EN
    // Timeout with TIMEOUT=8: len 5, two bytes, then silence
    do_reset();
    a_req = 1'b1;
    a_len = 8'd5;
    tick();
    a_req = 1'b0;
    a_byte(8'hC1);
    a_byte(8'hC2);
    for (int i = 0; i < 7; i++) tick();
    chk("t6_err_early", err, 0);
    chk("t6_gnt_held", a_gnt, 1);
    tick();
    chk("t6_err", err, 1);
    chk("t6_gnt_drop", a_gnt, 0);
    chk("t6_no_done", a_done, 0);
    chk("t6_fill", fill, 2);
    tick();
    chk("t6_err_pulse", err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
